// File: rtl/candy_ctrl.sv
// candy_ctrl: control FSM for the candy machine coin accumulator.
// Sequences the accumulator datapath (ld/op/clr/sel) for coin credit and
// vending, and streams change/refund coins to the hopper over valid/ready.
// Optional feature macro: CANDY_CTRL_CHANGE_EN enables the SNAP/CHANGE/CLEAR
// path, the cancel input and the idle-timeout refund. Without it a vend
// returns straight to IDLE and leftover credit carries over.
module candy_ctrl #(
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_sel,
  input  logic       cancel,
  input  logic [7:0] total,
  input  logic       cmp_ge80,
  output logic       ld,
  output logic       op,
  output logic       clr,
  output logic [1:0] sel,
  output logic       dispense,
  output logic       coin_reject,
  output logic       change_valid,
  output logic [1:0] change_coin,
  input  logic       change_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADD    = 3'd1,
    S_CHECK  = 3'd2,
    S_VEND   = 3'd3,
    S_SNAP   = 3'd4,
    S_CHANGE = 3'd5,
    S_CLEAR  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       ld_q, ld_d;
  logic       op_q, op_d;
  logic       clr_q, clr_d;
  logic       disp_q, disp_d;
  logic       rej_q, rej_d;
  logic       cv_q, cv_d;
  logic [1:0] cc_q, cc_d;
  logic       busy_q;
  logic       refund_req_s;

`ifdef CANDY_CTRL_CHANGE_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(IDLE_TIMEOUT);

  // Value in cents of a coin code.
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      2'b01:   v = 8'd5;
      2'b10:   v = 8'd10;
      2'b11:   v = 8'd25;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Largest coin that does not exceed the given amount.
  function automatic logic [1:0] largest_coin(input logic [7:0] amt);
    logic [1:0] c;
    if (amt >= 8'd25) begin
      c = 2'b11;
    end else if (amt >= 8'd10) begin
      c = 2'b10;
    end else if (amt >= 8'd5) begin
      c = 2'b01;
    end else begin
      c = 2'b00;
    end
    return c;
  endfunction

  logic [7:0]  rem_q, rem_d, rem_next_s;
  logic [15:0] cnt_q, cnt_d, cnt_inc_s;
  logic        timeout_hit_s;

  // The timeout fires on the IDLE cycle whose increment reaches the limit.
  assign cnt_inc_s     = cnt_q + 16'd1;
  assign timeout_hit_s = (TIMEOUT_LIM != 16'd0) && (total != 8'd0) && (cnt_inc_s == TIMEOUT_LIM);
  assign refund_req_s  = (total != 8'd0) && (cancel || timeout_hit_s);
  // cc_q always holds largest_coin(rem_q) while in CHANGE.
  assign rem_next_s    = rem_q - coin_value(cc_q);
`else
  logic unused_s;
  assign refund_req_s = 1'b0;
  assign unused_s     = ^{cancel, change_ready, total, 16'(IDLE_TIMEOUT)};
`endif

  // Next-state and next-output decode; outputs take their value for the state being entered.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ld_d    = 1'b0;
    op_d    = 1'b0;
    clr_d   = 1'b0;
    disp_d  = 1'b0;
    rej_d   = coin_valid;
    cv_d    = 1'b0;
    cc_d    = 2'b00;
`ifdef CANDY_CTRL_CHANGE_EN
    rem_d   = rem_q;
    cnt_d   = 16'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (refund_req_s) begin
          state_d = S_SNAP;
        end else if (coin_valid && (coin_sel != 2'b00)) begin
          state_d = S_ADD;
          sel_d   = coin_sel;
          ld_d    = 1'b1;
          op_d    = 1'b1;
          rej_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
`ifdef CANDY_CTRL_CHANGE_EN
          cnt_d   = (total != 8'd0) ? cnt_inc_s : 16'd0;
`endif
        end
      end
      S_ADD: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cmp_ge80) begin
          state_d = S_VEND;
          disp_d  = 1'b1;
          ld_d    = 1'b1;
          op_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VEND: begin
`ifdef CANDY_CTRL_CHANGE_EN
        state_d = S_SNAP;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef CANDY_CTRL_CHANGE_EN
      S_SNAP: begin
        rem_d = total;
        if (total == 8'd0) begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
        end else begin
          state_d = S_CHANGE;
          cv_d    = 1'b1;
          cc_d    = largest_coin(total);
        end
      end
      S_CHANGE: begin
        if (change_ready) begin
          rem_d = rem_next_s;
          if (rem_next_s < 8'd5) begin
            state_d = S_CLEAR;
            clr_d   = 1'b1;
          end else begin
            cv_d = 1'b1;
            cc_d = largest_coin(rem_next_s);
          end
        end else begin
          cv_d = 1'b1;
          cc_d = cc_q;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output update; rst drops any pending request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      ld_q    <= 1'b0;
      op_q    <= 1'b0;
      clr_q   <= 1'b0;
      disp_q  <= 1'b0;
      rej_q   <= 1'b0;
      cv_q    <= 1'b0;
      cc_q    <= 2'b00;
      busy_q  <= 1'b0;
`ifdef CANDY_CTRL_CHANGE_EN
      rem_q   <= 8'd0;
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      op_q    <= op_d;
      clr_q   <= clr_d;
      disp_q  <= disp_d;
      rej_q   <= rej_d;
      cv_q    <= cv_d;
      cc_q    <= cc_d;
      busy_q  <= (state_d != S_IDLE);
`ifdef CANDY_CTRL_CHANGE_EN
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ld           = ld_q;
  assign op           = op_q;
  assign clr          = clr_q;
  assign sel          = sel_q;
  assign dispense     = disp_q;
  assign coin_reject  = rej_q;
  assign change_valid = cv_q;
  assign change_coin  = cc_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_candy_ctrl.sv
// tb_candy_ctrl: randomized + directed bench for candy_ctrl with an
// accumulator datapath emulation and a transaction-level reference model.
`timescale 1ns/1ps
module tb_candy_ctrl;
  localparam int TO = 8;
`ifdef CANDY_CTRL_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel = 2'b00;
  logic       cancel = 1'b0;
  logic       change_ready = 1'b0;
  logic [7:0] total;
  logic       cmp_ge80;
  logic       ld, op, clr, dispense, coin_reject, change_valid, busy;
  logic [1:0] sel, change_coin;

  candy_ctrl #(.IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .cancel(cancel), .total(total), .cmp_ge80(cmp_ge80), .ld(ld), .op(op),
    .clr(clr), .sel(sel), .dispense(dispense), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_coin(change_coin),
    .change_ready(change_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cval(input logic [1:0] c);
    case (c)
      2'b01:   return 8'd5;
      2'b10:   return 8'd10;
      2'b11:   return 8'd25;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [1:0] big(input int amt);
    if (amt >= 25) return 2'b11;
    else if (amt >= 10) return 2'b10;
    else if (amt >= 5) return 2'b01;
    else return 2'b00;
  endfunction

  // Accumulator datapath driven by the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) total <= 8'd0;
    else if (clr) total <= 8'd0;
    else if (ld) total <= op ? (total + cval(sel)) : (total - 8'd80);
  end
  assign cmp_ge80 = (total >= 8'd80);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic ld; logic op; logic clr; logic disp; logic busy; logic cv; logic [1:0] cc; logic rej;
  } exp_t;

  exp_t       cur = '0;
  exp_t       sched[$];
  int         credit, rem, pay_after, idle_cnt, cyc;
  bit         paying;
  logic [1:0] m_sel;

  int n_checks = 0;
  int n_err = 0;
  int hs[$];
  int disp_cnt, disp_cyc, cv_cnt;

  function automatic exp_t ph(input logic l, input logic o, input logic c, input logic d);
    exp_t e = '0;
    e.ld = l; e.op = o; e.clr = c; e.disp = d; e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t chg(input int amt);
    exp_t e = ph(1'b0, 1'b0, 1'b0, 1'b0);
    e.cv = 1'b1;
    e.cc = big(amt);
    return e;
  endfunction

  task automatic model_reset();
    cur = '0; sched.delete(); credit = 0; rem = 0; pay_after = 0;
    idle_cnt = 0; paying = 1'b0; m_sel = 2'b00;
  endtask

  task automatic model_step();
    logic r;
    int   nw;
    exp_t nx;
    r = 1'b0;
    if (!cur.busy) begin
      if (CHG && credit != 0 && (cancel || (idle_cnt + 1 == TO))) begin
        r = coin_valid;
        sched.push_back(ph(1'b0, 1'b0, 1'b0, 1'b0));
        pay_after = credit;
        idle_cnt = 0;
      end else if (coin_valid && coin_sel != 2'b00) begin
        m_sel = coin_sel;
        idle_cnt = 0;
        nw = credit + int'(cval(coin_sel));
        sched.push_back(ph(1'b1, 1'b1, 1'b0, 1'b0));
        sched.push_back(ph(1'b0, 1'b0, 1'b0, 1'b0));
        if (nw >= 80) begin
          sched.push_back(ph(1'b1, 1'b0, 1'b0, 1'b1));
          nw = nw - 80;
          if (CHG) begin
            sched.push_back(ph(1'b0, 1'b0, 1'b0, 1'b0));
            if (nw == 0) sched.push_back(ph(1'b0, 1'b0, 1'b1, 1'b0));
            else pay_after = nw;
          end
        end
        credit = nw;
      end else begin
        r = coin_valid;
        idle_cnt = (credit != 0) ? idle_cnt + 1 : 0;
      end
    end else begin
      r = coin_valid;
      if (paying && change_ready) begin
        rem = rem - int'(cval(big(rem)));
        if (rem == 0) begin
          paying = 1'b0;
          credit = 0;
          sched.push_back(ph(1'b0, 1'b0, 1'b1, 1'b0));
        end
      end
    end
    if (paying) nx = chg(rem);
    else if (sched.size() > 0) nx = sched.pop_front();
    else if (pay_after != 0) begin
      paying = 1'b1; rem = pay_after; pay_after = 0; nx = chg(rem);
    end else nx = '0;
    if (nx.clr) credit = 0;
    nx.rej = r;
    cur = nx;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, plus event logging.
  always @(negedge clk) begin
    chk("ld", int'(ld), int'(cur.ld));
    chk("op", int'(op), int'(cur.op));
    chk("clr", int'(clr), int'(cur.clr));
    chk("dispense", int'(dispense), int'(cur.disp));
    chk("coin_reject", int'(coin_reject), int'(cur.rej));
    chk("change_valid", int'(change_valid), int'(cur.cv));
    chk("change_coin", int'(change_coin), int'(cur.cc));
    chk("busy", int'(busy), int'(cur.busy));
    chk("sel", int'(sel), int'(m_sel));
    if (!cur.busy && !rst) chk("total_idle", int'(total), credit);
    if (change_valid && change_ready) hs.push_back(int'(change_coin));
    if (dispense) begin disp_cnt++; disp_cyc = cyc; end
    if (change_valid) cv_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    cyc++;
    #2;
  endtask

  task automatic coin(input logic [1:0] c);
    coin_valid = 1'b1; coin_sel = c;
    tick();
    coin_valid = 1'b0; coin_sel = 2'b00;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (cur.busy && n < 100) begin tick(); n++; end
    chk({nm, "_idle_bound"}, int'(n < 100), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    hs.delete(); disp_cnt = 0; cv_cnt = 0; disp_cyc = -1;
  endtask

`ifdef CANDY_CTRL_CHANGE_EN
  task automatic wait_cv(input string nm);
    int n = 0;
    while (!cur.cv && n < 30) begin tick(); n++; end
    chk({nm, "_cv_bound"}, int'(n < 30), 1);
  endtask

  task automatic chk_hs(input string nm, input int n, input int e0, input int e1);
    chk({nm, "_hs_n"}, hs.size(), n);
    if (hs.size() > 0 && n > 0) chk({nm, "_hs0"}, hs[0], e0);
    if (hs.size() > 1 && n > 1) chk({nm, "_hs1"}, hs[1], e1);
  endtask
`endif

  initial begin
    int c0, n;
    model_reset();
    clear_logs();
    cyc = 0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_total", int'(total), 0);
    rst = 1'b0;
    tick();

    // 25+25+25+10 = 85
    clear_logs(); change_ready = 1'b1;
    coin(2'b11); wait_idle("t1a");
    coin(2'b11); wait_idle("t1b");
    coin(2'b11); wait_idle("t1c");
    c0 = cyc;
    coin(2'b10); wait_idle("t1d");
    chk("t1_disp_cnt", disp_cnt, 1);
    chk("t1_disp_lat", disp_cyc - c0, 3);
`ifdef CANDY_CTRL_CHANGE_EN
    chk_hs("t1", 1, 1, 0);
    chk("t1_total", int'(total), 0);
`else
    chk("t1_cv_cnt", cv_cnt, 0);
    chk("t1_total", int'(total), 5);
`endif

    // 4 x 25 = 100, hopper stalls
    do_reset(); clear_logs(); change_ready = 1'b0;
    coin(2'b11); wait_idle("t2a");
    coin(2'b11); wait_idle("t2b");
    coin(2'b11); wait_idle("t2c");
    coin(2'b11);
`ifdef CANDY_CTRL_CHANGE_EN
    wait_cv("t2");
    for (int i = 0; i < 4; i++) begin
      chk("t2_stable_coin", int'(change_coin), 2);
      tick();
    end
    change_ready = 1'b1;
    wait_idle("t2d");
    chk_hs("t2", 2, 2, 2);
    chk("t2_total", int'(total), 0);
`else
    wait_idle("t2d");
    chk("t2_total", int'(total), 20);
    chk("t2_cv_cnt", cv_cnt, 0);
`endif
    chk("t2_disp_cnt", disp_cnt, 1);

    // credit 35, then cancel together with a coin
    do_reset(); clear_logs(); change_ready = 1'b1;
    coin(2'b11); wait_idle("t3a");
    coin(2'b10); wait_idle("t3b");
    cancel = 1'b1; coin(2'b01); cancel = 1'b0;
`ifdef CANDY_CTRL_CHANGE_EN
    chk("t3_reject", int'(coin_reject), 1);
    wait_idle("t3c");
    chk_hs("t3", 2, 3, 2);
    chk("t3_total", int'(total), 0);
`else
    chk("t3_reject", int'(coin_reject), 0);
    wait_idle("t3c");
    chk("t3_total", int'(total), 40);
`endif
    chk("t3_disp_cnt", disp_cnt, 0);

    // coin while busy, then reset mid-transaction
    do_reset(); clear_logs();
    coin(2'b11);
    coin_valid = 1'b1; coin_sel = 2'b10; tick(); coin_valid = 1'b0; coin_sel = 2'b00;
    chk("t4_busy_reject", int'(coin_reject), 1);
    rst = 1'b1; model_reset(); #1;
    chk("t4_rst_busy", int'(busy), 0);
    tick(); rst = 1'b0;
`ifdef CANDY_CTRL_CHANGE_EN
    change_ready = 1'b0;
    coin(2'b11); wait_idle("t4a");
    coin(2'b11); wait_idle("t4b");
    coin(2'b11); wait_idle("t4c");
    coin(2'b11); wait_cv("t4");
    coin_valid = 1'b1; coin_sel = 2'b10; tick(); coin_valid = 1'b0; coin_sel = 2'b00;
    chk("t4_change_reject", int'(coin_reject), 1);
    chk("t4_change_total", int'(total), 20);
    rst = 1'b1; model_reset(); #1;
    chk("t4_rst_cv", int'(change_valid), 0);
    chk("t4_rst_busy2", int'(busy), 0);
    tick(); rst = 1'b0;
`endif

    // idle timeout with credit 15
    do_reset(); clear_logs(); change_ready = 1'b1;
    coin(2'b10); wait_idle("t5a");
    coin(2'b01); wait_idle("t5b");
    n = 0;
    while (!busy && n < 30) begin tick(); n++; end
`ifdef CANDY_CTRL_CHANGE_EN
    chk("t5_idle_cycles", n, 8);
    wait_idle("t5c");
    chk_hs("t5", 2, 2, 1);
    chk("t5_total", int'(total), 0);
`else
    chk("t5_no_timeout", n, 30);
    chk("t5_total", int'(total), 15);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      coin_valid   = ($urandom_range(0, 2) == 0);
      coin_sel     = 2'($urandom_range(0, 3));
      cancel       = ($urandom_range(0, 15) == 0);
      change_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    coin_valid = 1'b0; cancel = 1'b0; change_ready = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
